// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write port, scoreboard alloc and ready.
// The decode/writeback side uses the master modport and the register file uses the slave modport.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic                   ready;
  logic [NRD*ADDR_W-1:0]  rd_addr;
  logic [NRD*DATA_W-1:0]  rd_data;
  logic [NRD-1:0]         rd_busy;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   alloc_en;
  logic [ADDR_W-1:0]      alloc_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with an optional zero register, write bypass
// and a per-entry pending scoreboard; storage is cleared by a one-entry-per-cycle sweep.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [NRD*DATA_W-1:0] rd_data_s;
  logic [NRD-1:0]        rd_busy_s;
  logic [ADDR_W-1:0]     rd_addr_s;

  function automatic logic zero_blocked(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == {ADDR_W{1'b0}});
  endfunction

  // Next state, sweep counter, scoreboard and the single RAM write port.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = {DATA_W{1'b0}};
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        if (bus.wr_en && !zero_blocked(bus.wr_addr)) begin
          mem_we                = 1'b1;
          pend_d[bus.wr_addr]   = 1'b0;
        end else begin
          mem_we = 1'b0;
        end
        // Alloc is applied after the write so a same-cycle newer producer wins.
        if (bus.alloc_en && !zero_blocked(bus.alloc_addr)) begin
          pend_d[bus.alloc_addr] = 1'b1;
        end else begin
          pend_d = pend_d;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= {ADDR_W{1'b0}};
      pend_q  <= {DEPTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Storage array without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Independent combinational read ports.
  always_comb begin
    rd_data_s = {(NRD*DATA_W){1'b0}};
    rd_busy_s = {NRD{1'b0}};
    rd_addr_s = {ADDR_W{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      rd_addr_s = bus.rd_addr[k*ADDR_W +: ADDR_W];
      if (state_q != ST_READY) begin
        rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_busy_s[k]                  = 1'b0;
      end else if (zero_blocked(rd_addr_s)) begin
        rd_data_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_busy_s[k]                  = 1'b0;
      end else if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == rd_addr_s)) begin
        rd_data_s[k*DATA_W +: DATA_W] = bus.wr_data;
        rd_busy_s[k]                  = 1'b0;
      end else begin
        rd_data_s[k*DATA_W +: DATA_W] = mem_q[rd_addr_s];
        rd_busy_s[k]                  = pend_q[rd_addr_s];
      end
    end
  end

  assign bus.rd_data = rd_data_s;
  assign bus.rd_busy = rd_busy_s;
  assign bus.ready   = (state_q == ST_READY);
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, a no-bypass/no-zero build and a small
// 4-port build, all sharing clock and reset.
module tb_regfile_mp;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) b0 ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) b1 ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(3), .NRD(4)) b2 ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(0), .BYPASS(0))
    u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4), .ZERO_REG(1), .BYPASS(1))
    u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b0.rd_addr = 10'd0; b0.wr_en = 1'b0; b0.wr_addr = 5'd0; b0.wr_data = 32'd0;
    b0.alloc_en = 1'b0; b0.alloc_addr = 5'd0;
    b1.rd_addr = 10'd0; b1.wr_en = 1'b0; b1.wr_addr = 5'd0; b1.wr_data = 32'd0;
    b1.alloc_en = 1'b0; b1.alloc_addr = 5'd0;
    b2.rd_addr = 12'd0; b2.wr_en = 1'b0; b2.wr_addr = 3'd0; b2.wr_data = 16'd0;
    b2.alloc_en = 1'b0; b2.alloc_addr = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b0.rd_addr = {5'd31, 5'd3};
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e < 32) begin
        n_checks++;
        if (b0.ready !== 1'b0) begin
          n_fail++; $display("FAIL reset_ready_low edge %0d: got %b expected 0", e, b0.ready);
        end
      end else begin
        n_checks++;
        if (b0.ready !== 1'b1 || b1.ready !== 1'b1) begin
          n_fail++; $display("FAIL reset_ready_high: got %b/%b expected 1/1", b0.ready, b1.ready);
        end
      end
      if (e == 5) begin
        n_checks++;
        if (b0.rd_data !== 64'd0 || b0.rd_busy !== 2'b00) begin
          n_fail++; $display("FAIL sweep_read_zero: got %h/%b expected 0/00", b0.rd_data, b0.rd_busy);
        end
      end
      if (e == 7 || e == 8) begin
        n_checks++;
        if (b2.ready !== (e == 8)) begin
          n_fail++; $display("FAIL small_ready edge %0d: got %b expected %b", e, b2.ready, (e == 8));
        end
      end
    end
    for (int a = 0; a < 32; a++) begin
      b0.rd_addr = {5'(a), 5'(a)};
      b1.rd_addr = {5'(a), 5'(a)};
      #1;
      n_checks++;
      if (b0.rd_data !== 64'd0 || b0.rd_busy !== 2'b00 || b1.rd_data !== 64'd0 || b1.rd_busy !== 2'b00) begin
        n_fail++; $display("FAIL cleared_entry r%0d: got %h/%b %h/%b expected 0", a,
                           b0.rd_data, b0.rd_busy, b1.rd_data, b1.rd_busy);
      end
    end
  endtask

  task automatic test_mid_sweep();
    int first;
    first = 0;
    rst = 1'b1;
    tick();
    n_checks++;
    if (b0.ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_falls_on_reset: got %b expected 0", b0.ready);
    end
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (b0.ready === 1'b1 && first == 0) first = e;
    end
    n_checks++;
    if (first != 32) begin
      n_fail++; $display("FAIL mid_sweep_restart: ready after %0d edges, expected 32", first);
    end
  endtask

  task automatic test_write_read();
    b0.wr_en = 1'b1; b0.wr_addr = 5'd5; b0.wr_data = 32'hDEADBEEF; b0.rd_addr = {5'd5, 5'd5};
    b1.wr_en = 1'b1; b1.wr_addr = 5'd5; b1.wr_data = 32'hDEADBEEF; b1.rd_addr = {5'd5, 5'd5};
    #1;
    n_checks++;
    if (b0.rd_data !== {2{32'hDEADBEEF}}) begin
      n_fail++; $display("FAIL bypass_write_cycle: got %h expected %h", b0.rd_data, {2{32'hDEADBEEF}});
    end
    n_checks++;
    if (b1.rd_data !== 64'd0) begin
      n_fail++; $display("FAIL nobypass_write_cycle: got %h expected 0", b1.rd_data);
    end
    tick();
    b0.wr_en = 1'b0; b1.wr_en = 1'b0;
    #1;
    n_checks++;
    if (b0.rd_data !== {2{32'hDEADBEEF}} || b1.rd_data !== {2{32'hDEADBEEF}}) begin
      n_fail++; $display("FAIL write_then_read: got %h %h expected %h", b0.rd_data, b1.rd_data, {2{32'hDEADBEEF}});
    end
  endtask

  task automatic test_zero_reg();
    b0.wr_en = 1'b1; b0.wr_addr = 5'd0; b0.wr_data = 32'h12345678;
    b0.alloc_en = 1'b1; b0.alloc_addr = 5'd0; b0.rd_addr = 10'd0;
    b1.wr_en = 1'b1; b1.wr_addr = 5'd0; b1.wr_data = 32'h12345678;
    b1.alloc_en = 1'b1; b1.alloc_addr = 5'd0; b1.rd_addr = 10'd0;
    #1;
    n_checks++;
    if (b0.rd_data !== 64'd0) begin
      n_fail++; $display("FAIL zero_reg_no_bypass: got %h expected 0", b0.rd_data);
    end
    tick();
    b0.wr_en = 1'b0; b0.alloc_en = 1'b0;
    b1.wr_en = 1'b0; b1.alloc_en = 1'b0;
    #1;
    n_checks++;
    if (b0.rd_data !== 64'd0 || b0.rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL zero_reg_read: got %h/%b expected 0/00", b0.rd_data, b0.rd_busy);
    end
    n_checks++;
    if (b1.rd_data !== {2{32'h12345678}} || b1.rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL r0_plain_read: got %h/%b expected %h/11", b1.rd_data, b1.rd_busy, {2{32'h12345678}});
    end
  endtask

  task automatic test_scoreboard();
    b0.alloc_en = 1'b1; b0.alloc_addr = 5'd7; b0.rd_addr = {5'd7, 5'd7};
    b1.alloc_en = 1'b1; b1.alloc_addr = 5'd7; b1.rd_addr = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (b0.rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL alloc_same_cycle: got %b expected 00", b0.rd_busy);
    end
    tick();
    b0.alloc_en = 1'b0; b1.alloc_en = 1'b0;
    #1;
    n_checks++;
    if (b0.rd_busy !== 2'b11 || b1.rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL alloc_next_cycle: got %b %b expected 11", b0.rd_busy, b1.rd_busy);
    end
    b0.wr_en = 1'b1; b0.wr_addr = 5'd7; b0.wr_data = 32'h55;
    b1.wr_en = 1'b1; b1.wr_addr = 5'd7; b1.wr_data = 32'h55;
    #1;
    n_checks++;
    if (b0.rd_data !== {2{32'h55}} || b0.rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL write_clears_busy_bypass: got %h/%b expected 55/00", b0.rd_data, b0.rd_busy);
    end
    n_checks++;
    if (b1.rd_data !== 64'd0 || b1.rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL nobypass_old_pending: got %h/%b expected 0/11", b1.rd_data, b1.rd_busy);
    end
    tick();
    b0.wr_en = 1'b0; b1.wr_en = 1'b0;
    #1;
    n_checks++;
    if (b0.rd_data !== {2{32'h55}} || b0.rd_busy !== 2'b00 || b1.rd_data !== {2{32'h55}} || b1.rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL write_retired: got %h/%b %h/%b expected 55/00", b0.rd_data, b0.rd_busy, b1.rd_data, b1.rd_busy);
    end
    b0.wr_en = 1'b1; b0.wr_addr = 5'd7; b0.wr_data = 32'hA5A5;
    b0.alloc_en = 1'b1; b0.alloc_addr = 5'd7;
    tick();
    b0.wr_en = 1'b0; b0.alloc_en = 1'b0;
    #1;
    n_checks++;
    if (b0.rd_data !== {2{32'hA5A5}} || b0.rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL write_alloc_same: got %h/%b expected a5a5/11", b0.rd_data, b0.rd_busy);
    end
  endtask

  task automatic test_params();
    for (int i = 0; i < 8; i++) begin
      b2.wr_en   = 1'b1;
      b2.wr_addr = 3'(i);
      b2.wr_data = 16'h1000 + 16'(i) * 16'h0111;
      tick();
    end
    b2.wr_en = 1'b0;
    b2.rd_addr = {3'd7, 3'd5, 3'd3, 3'd1};
    #1;
    n_checks++;
    if (b2.rd_data !== {16'h1777, 16'h1555, 16'h1333, 16'h1111} || b2.rd_busy !== 4'b0000) begin
      n_fail++; $display("FAIL four_port_odd: got %h/%b expected 1777155513331111/0000", b2.rd_data, b2.rd_busy);
    end
    b2.rd_addr = {3'd0, 3'd6, 3'd4, 3'd2};
    #1;
    n_checks++;
    if (b2.rd_data !== {16'h0000, 16'h1666, 16'h1444, 16'h1222}) begin
      n_fail++; $display("FAIL four_port_even: got %h expected 0000166614441222", b2.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    b0.wr_en = 1'b1; b0.wr_addr = 5'd10; b0.wr_data = 32'hAAAA0001; b0.rd_addr = {5'd10, 5'd10};
    #1;
    n_checks++;
    if (b0.rd_data !== {32'hAAAA0001, 32'hAAAA0001}) begin
      n_fail++; $display("FAIL b2b_cycle1: got %h", b0.rd_data);
    end
    tick();
    b0.wr_addr = 5'd11; b0.wr_data = 32'hBBBB0002; b0.rd_addr = {5'd11, 5'd10};
    #1;
    n_checks++;
    if (b0.rd_data !== {32'hBBBB0002, 32'hAAAA0001}) begin
      n_fail++; $display("FAIL b2b_cycle2: got %h expected bbbb0002aaaa0001", b0.rd_data);
    end
    tick();
    b0.wr_addr = 5'd12; b0.wr_data = 32'hCCCC0003; b0.rd_addr = {5'd12, 5'd11};
    #1;
    n_checks++;
    if (b0.rd_data !== {32'hCCCC0003, 32'hBBBB0002}) begin
      n_fail++; $display("FAIL b2b_cycle3: got %h expected cccc0003bbbb0002", b0.rd_data);
    end
    tick();
    b0.wr_en = 1'b0; b0.rd_addr = {5'd12, 5'd10};
    #1;
    n_checks++;
    if (b0.rd_data !== {32'hCCCC0003, 32'hAAAA0001}) begin
      n_fail++; $display("FAIL b2b_after: got %h expected cccc0003aaaa0001", b0.rd_data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_all();
    test_reset();
    test_mid_sweep();
    test_write_read();
    idle_all();
    test_zero_reg();
    idle_all();
    test_scoreboard();
    idle_all();
    test_params();
    idle_all();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the MIPS datapath, the next generation of the 32×32 two-read/one-write register file. Adds configurable width, depth and read-port count, an optional hard-wired zero register, optional write-to-read bypass, and a per-register pending scoreboard. Reset is synchronous and clears storage with a one-entry-per-cycle sweep, so the array maps to RAM without a global clear. Sits between the decode stage (reads, allocs) and the writeback stage (writes).

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as 0, ignores writes and allocs, and is never pending
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  1 = clear sweep done, array usable
- rd_addr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational; port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NRD  pending bit of the addressed entry, per port
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- alloc_en  in  1  mark an entry pending (producer issued)
- alloc_addr  in  ADDR_W  entry to mark pending

## Operation
- States: CLEAR and READY. A 2-bit state register is sufficient.
- rst high: state <= CLEAR, sweep counter cnt <= 0, all pending bits <= 0, ready = 0.
- CLEAR with rst low: write 0 to entry cnt and increment cnt each cycle. After entry DEPTH-1 is written, go to READY. wr_en and alloc_en are ignored. rd_data = 0 and rd_busy = 0 on all ports.
- READY: ready = 1. The block stays in READY until rst is asserted.
- Write: when wr_en is high and the address is not a blocked zero entry, mem[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Alloc: when alloc_en is high and the address is not a blocked zero entry, pending[alloc_addr] <= 1.
- Write and alloc to the same address in the same cycle: the data is written and pending ends at 1, because the alloc represents a newer producer.
- Read port k:
  - If ZERO_REG=1 and addr = 0: data 0, busy 0.
  - Else if BYPASS=1, wr_en is high and wr_addr = addr: data = wr_data, busy 0.
  - Else: data = mem[addr], busy = pending[addr].
- All read ports are independent and may address the same entry.
- An alloc in the current cycle does not affect rd_busy until the next cycle.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, and from the wr_* inputs when BYPASS=1).
- Write latency: 1 cycle. Data is visible on a non-bypassed read in the cycle after the wr_en edge.
- Sweep: ready rises DEPTH rising edges after the first edge that samples rst low (32 edges at defaults).
- rst asserted mid-sweep restarts the sweep from cnt = 0.
- rst asserted while READY: ready falls on that same edge and the full sweep repeats.
- Output values during and after reset until READY: ready 0, rd_data all 0, rd_busy all 0.
- With BYPASS=0, a read of wr_addr in the write cycle returns the old data and the old pending bit.

## Test plan
- Reset sweep: pulse rst for 1 cycle -> ready stays 0 for 32 edges, then 1. Every entry then reads 0 and every pending bit is 0.
- Mid-sweep reset: reassert rst at sweep cycle 10 -> ready rises 32 edges after rst deasserts again, not 22.
- Write and read: write 0xDEADBEEF to r5, then read r5 on both ports next cycle -> both ports return 0xDEADBEEF. In the write cycle itself, BYPASS=1 returns 0xDEADBEEF and BYPASS=0 returns the old value 0.
- Zero register: write 0x12345678 to r0 and alloc r0 -> reads of r0 return 0 with busy 0. With ZERO_REG=0, the same sequence gives 0x12345678 and busy 1.
- Scoreboard: alloc r7 -> rd_busy = 1 on the next cycle. Write r7 = 0x55 -> busy 0 on the write cycle (BYPASS=1) and 0x55 thereafter. Write r7 and alloc r7 in the same cycle -> r7 holds the new data with busy 1.
- Parametrisation: DATA_W=16, ADDR_W=3, NRD=4 -> sweep completes in 8 cycles. Four simultaneous reads of distinct addresses each return their last-written values.
